// File: rtl/rca_fault_sel_ctrl_if.sv
// Bus between the duplexed adder pair and the fault-select controller.
// The controller receives the two adder results and drives the mux select,
// the test-operand override and the status flags.
interface rca_fault_sel_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             valid_in;
  logic [WIDTH:0]   sum_p;
  logic [WIDTH:0]   sum_s;
  logic             sel;
  logic             test_en;
  logic [WIDTH-1:0] test_a;
  logic [WIDTH-1:0] test_b;
  logic             test_cin;
  logic             busy;
  logic             fault_p;
  logic             fault_s;
  logic             err;
  logic [7:0]       trans_cnt;

  // Adder/datapath side: supplies results, consumes select and test controls.
  modport master (
    output valid_in, sum_p, sum_s,
    input  sel, test_en, test_a, test_b, test_cin,
    input  busy, fault_p, fault_s, err, trans_cnt
  );

  // Controller side.
  modport slave (
    input  valid_in, sum_p, sum_s,
    output sel, test_en, test_a, test_b, test_cin,
    output busy, fault_p, fault_s, err, trans_cnt
  );
endinterface

// File: rtl/rca_fault_sel_ctrl.sv
// Fault-select controller for a primary/spare ripple-carry adder pair.
// Duplex-compares the two sums; after THRESH consecutive mismatches it drives
// two known test vectors into both adders, decides which adder is broken and
// steers the output mux to the healthy one. All outputs are registered.
module rca_fault_sel_ctrl #(
  parameter int WIDTH   = 4,
  parameter int THRESH  = 3,
  parameter int TIMEOUT = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  rca_fault_sel_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    NORMAL, DRV1, WAIT1, DRV2, WAIT2, SPARE, PRI_ONLY, FAILED
  } state_t;

  // Vector 1: all-ones + 0 + cin=1 ripples a carry through every stage.
  // Vector 2: 1010.. + 0101.. + cin=0 gives all-ones with no carry at all.
  localparam logic [WIDTH:0] E1 = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] E2 = {1'b0, {WIDTH{1'b1}}};
  localparam logic [3:0]     THRESH_C = 4'(THRESH);
  localparam int             TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMR_LAST = TW'(TIMEOUT - 1);

  state_t           state_reg;
  logic [3:0]       mis_cnt_reg;
  logic [TW-1:0]    tmr_reg;
  logic             pf_reg, sf_reg;
  logic             sel_reg, test_en_reg, test_cin_reg, busy_reg;
  logic             fault_p_reg, fault_s_reg, err_reg;
  logic [WIDTH-1:0] test_a_reg, test_b_reg;
  logic [7:0]       trans_cnt_reg;

  // Alternating pattern with a 1 in every odd bit position (..1010).
  logic [WIDTH-1:0] alt_pat;
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_alt
    assign alt_pat[gi] = (gi % 2 == 1);
  end

  logic [3:0] mis_inc;
  logic       pf_next, sf_next;
  assign mis_inc = mis_cnt_reg + 4'd1;
  // Final verdict folds the vector-2 comparison into the vector-1 result.
  assign pf_next = pf_reg | (bus.sum_p != E2);
  assign sf_next = sf_reg | (bus.sum_s != E2);

  // Controller FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= NORMAL;
      mis_cnt_reg   <= '0;
      tmr_reg       <= '0;
      pf_reg        <= 1'b0;
      sf_reg        <= 1'b0;
      sel_reg       <= 1'b0;
      test_en_reg   <= 1'b0;
      test_a_reg    <= '0;
      test_b_reg    <= '0;
      test_cin_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      fault_p_reg   <= 1'b0;
      fault_s_reg   <= 1'b0;
      err_reg       <= 1'b0;
      trans_cnt_reg <= '0;
    end else begin
      case (state_reg)
        NORMAL: begin
          if (bus.valid_in) begin
            if (bus.sum_p != bus.sum_s) begin
              if (mis_inc == THRESH_C) begin
                mis_cnt_reg  <= '0;
                state_reg    <= DRV1;
                test_en_reg  <= 1'b1;
                busy_reg     <= 1'b1;
                test_a_reg   <= '1;
                test_b_reg   <= '0;
                test_cin_reg <= 1'b1;
              end else begin
                mis_cnt_reg <= mis_inc;
              end
            end else begin
              mis_cnt_reg <= '0;
            end
          end
        end
        // Give the adders one cycle to settle on the forced operands.
        DRV1: begin
          state_reg <= WAIT1;
          tmr_reg   <= '0;
        end
        WAIT1: begin
          if (bus.valid_in) begin
            pf_reg       <= (bus.sum_p != E1);
            sf_reg       <= (bus.sum_s != E1);
            state_reg    <= DRV2;
            test_a_reg   <= alt_pat;
            test_b_reg   <= ~alt_pat;
            test_cin_reg <= 1'b0;
          end else if (tmr_reg == TMR_LAST) begin
            state_reg    <= FAILED;
            err_reg      <= 1'b1;
            sel_reg      <= 1'b0;
            test_en_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            test_a_reg   <= '0;
            test_b_reg   <= '0;
            test_cin_reg <= 1'b0;
          end else begin
            tmr_reg <= tmr_reg + 1'b1;
          end
        end
        DRV2: begin
          state_reg <= WAIT2;
          tmr_reg   <= '0;
        end
        WAIT2: begin
          if (bus.valid_in || tmr_reg == TMR_LAST) begin
            test_en_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            test_a_reg   <= '0;
            test_b_reg   <= '0;
            test_cin_reg <= 1'b0;
          end
          if (bus.valid_in) begin
            pf_reg <= pf_next;
            sf_reg <= sf_next;
            case ({pf_next, sf_next})
              2'b10: begin
                fault_p_reg <= 1'b1;
                sel_reg     <= 1'b1;
                state_reg   <= SPARE;
              end
              2'b01: begin
                fault_s_reg <= 1'b1;
                sel_reg     <= 1'b0;
                state_reg   <= PRI_ONLY;
              end
              2'b00: begin
                if (trans_cnt_reg != 8'hFF) trans_cnt_reg <= trans_cnt_reg + 8'd1;
                state_reg <= NORMAL;
              end
              default: begin
                err_reg   <= 1'b1;
                sel_reg   <= 1'b0;
                state_reg <= FAILED;
              end
            endcase
          end else if (tmr_reg == TMR_LAST) begin
            err_reg   <= 1'b1;
            sel_reg   <= 1'b0;
            state_reg <= FAILED;
          end else begin
            tmr_reg <= tmr_reg + 1'b1;
          end
        end
        // SPARE, PRI_ONLY and FAILED hold until reset.
        default: begin
          state_reg <= state_reg;
        end
      endcase
    end
  end

  assign bus.sel       = sel_reg;
  assign bus.test_en   = test_en_reg;
  assign bus.test_a    = test_a_reg;
  assign bus.test_b    = test_b_reg;
  assign bus.test_cin  = test_cin_reg;
  assign bus.busy      = busy_reg;
  assign bus.fault_p   = fault_p_reg;
  assign bus.fault_s   = fault_s_reg;
  assign bus.err       = err_reg;
  assign bus.trans_cnt = trans_cnt_reg;

endmodule

// File: tb/tb_rca_fault_sel_ctrl.sv
// Directed bench for rca_fault_sel_ctrl (WIDTH=4, THRESH=3, TIMEOUT=8).
module tb_rca_fault_sel_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rca_fault_sel_ctrl_if #(.WIDTH(4)) bus ();

  rca_fault_sel_ctrl #(.WIDTH(4), .THRESH(3), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [4:0] p, input logic [4:0] s);
    bus.valid_in = v;
    bus.sum_p    = p;
    bus.sum_s    = s;
    @(posedge clk);
    #1;
    $display("t=%0t rst_n=%0b v=%0b p=%h s=%h -> sel=%0b ten=%0b a=%h b=%h cin=%0b busy=%0b fp=%0b fs=%0b err=%0b tc=%0d",
             $time, rst_n, v, p, s, bus.sel, bus.test_en, bus.test_a, bus.test_b,
             bus.test_cin, bus.busy, bus.fault_p, bus.fault_s, bus.err, bus.trans_cnt);
  endtask

  task automatic chk_st(input string tag, input logic sel, input logic ten, input logic busy,
                        input logic fp, input logic fs, input logic err);
    check({tag, ".sel"},     bus.sel,     sel);
    check({tag, ".test_en"}, bus.test_en, ten);
    check({tag, ".busy"},    bus.busy,    busy);
    check({tag, ".fault_p"}, bus.fault_p, fp);
    check({tag, ".fault_s"}, bus.fault_s, fs);
    check({tag, ".err"},     bus.err,     err);
  endtask

  task automatic chk_vec(input string tag, input logic [3:0] a, input logic [3:0] b, input logic cin);
    check({tag, ".test_a"},   bus.test_a,   a);
    check({tag, ".test_b"},   bus.test_b,   b);
    check({tag, ".test_cin"}, bus.test_cin, cin);
  endtask

  task automatic chk_reset(input string tag);
    chk_st(tag, 0, 0, 0, 0, 0, 0);
    chk_vec(tag, 4'h0, 4'h0, 1'b0);
    check({tag, ".trans_cnt"}, bus.trans_cnt, 8'd0);
  endtask

  // Three consecutive mismatches starting from a cleared counter.
  task automatic trigger();
    step(1, 5'h01, 5'h02);
    step(1, 5'h03, 5'h04);
    step(1, 5'h05, 5'h06);
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.sum_p    = '0;
    bus.sum_s    = '0;

    // Reset state
    rst_n = 1'b0;
    step(0, 5'h00, 5'h00);
    step(1, 5'h01, 5'h02);
    chk_reset("reset");
    rst_n = 1'b1;

    // Matching sums never start a diagnosis
    for (int i = 0; i < 20; i++) begin
      step(1, 5'h0A, 5'h0A);
      check("match.test_en", bus.test_en, 1'b0);
    end
    chk_st("match", 0, 0, 0, 0, 0, 0);

    // mm, mm, match, mm, mm: counter cleared by the match
    step(1, 5'h01, 5'h02);
    step(1, 5'h01, 5'h02);
    step(1, 5'h07, 5'h07);
    step(0, 5'h01, 5'h02);   // idle cycle must not count
    step(1, 5'h01, 5'h02);
    step(1, 5'h01, 5'h02);
    check("clr.test_en", bus.test_en, 1'b0);
    step(1, 5'h01, 5'h02);   // third consecutive mismatch
    chk_st("drv1", 0, 1, 1, 0, 0, 0);
    chk_vec("drv1", 4'hF, 4'h0, 1'b1);

    // Primary wrong on vector 1, spare correct on both -> spare selected
    step(0, 5'h00, 5'h00);                      // DRV1 -> WAIT1
    chk_vec("wait1", 4'hF, 4'h0, 1'b1);
    check("wait1.busy", bus.busy, 1'b1);
    step(1, 5'h00, 5'h10);                      // result 1
    chk_st("drv2", 0, 1, 1, 0, 0, 0);
    chk_vec("drv2", 4'hA, 4'h5, 1'b0);
    step(0, 5'h00, 5'h00);                      // DRV2 -> WAIT2
    step(1, 5'h0F, 5'h0F);                      // result 2
    chk_st("spare", 1, 0, 0, 1, 0, 0);
    chk_vec("spare", 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1, 5'h01, 5'h02);
    chk_st("spare.hold", 1, 0, 0, 1, 0, 0);

    // Both correct -> transient, back to NORMAL
    rst_n = 1'b0;
    step(0, 5'h00, 5'h00);
    chk_reset("rst2");
    rst_n = 1'b1;
    trigger();
    step(1, 5'h1F, 5'h03);                      // valid during DRV1 is ignored
    chk_st("drv1.ign", 0, 1, 1, 0, 0, 0);
    chk_vec("drv1.ign", 4'hF, 4'h0, 1'b1);
    step(1, 5'h10, 5'h10);
    step(0, 5'h00, 5'h00);
    step(1, 5'h0F, 5'h0F);
    chk_st("trans", 0, 0, 0, 0, 0, 0);
    check("trans.cnt", bus.trans_cnt, 8'd1);
    step(1, 5'h01, 5'h02);
    step(1, 5'h01, 5'h02);
    check("retrig.early", bus.test_en, 1'b0);
    step(1, 5'h01, 5'h02);
    check("retrig.test_en", bus.test_en, 1'b1);
    check("retrig.test_a", bus.test_a, 4'hF);

    // valid_in never returns -> timeout after 8 cycles in WAIT1
    step(0, 5'h00, 5'h00);                      // DRV1 -> WAIT1
    for (int i = 0; i < 7; i++) step(0, 5'h00, 5'h00);
    chk_st("to.pre", 0, 1, 1, 0, 0, 0);
    step(0, 5'h00, 5'h00);
    chk_st("timeout", 0, 0, 0, 0, 0, 1);
    chk_vec("timeout", 4'h0, 4'h0, 1'b0);
    check("timeout.cnt", bus.trans_cnt, 8'd1);
    step(1, 5'h0A, 5'h0A);
    check("timeout.sticky", bus.err, 1'b1);
    rst_n = 1'b0;
    step(0, 5'h00, 5'h00);
    chk_reset("rst3");
    rst_n = 1'b1;

    // Spare wrong on vector 2 -> primary only
    trigger();
    step(0, 5'h00, 5'h00);
    step(1, 5'h10, 5'h10);
    step(0, 5'h00, 5'h00);
    step(1, 5'h0F, 5'h0E);
    chk_st("pri_only", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 5'h01, 5'h02);
    chk_st("pri_only.hold", 0, 0, 0, 0, 1, 0);

    // Both adders wrong -> unrecoverable
    rst_n = 1'b0;
    step(0, 5'h00, 5'h00);
    rst_n = 1'b1;
    trigger();
    step(0, 5'h00, 5'h00);
    step(1, 5'h11, 5'h10);
    step(0, 5'h00, 5'h00);
    step(1, 5'h0F, 5'h0E);
    chk_st("both", 0, 0, 0, 0, 0, 1);

    // Reset during WAIT2 aborts the diagnosis
    rst_n = 1'b0;
    step(0, 5'h00, 5'h00);
    rst_n = 1'b1;
    trigger();
    step(0, 5'h00, 5'h00);
    step(1, 5'h10, 5'h10);
    step(0, 5'h00, 5'h00);                      // now in WAIT2
    check("wait2.busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    step(1, 5'h0F, 5'h0E);
    chk_reset("rst.wait2");
    rst_n = 1'b1;
    step(1, 5'h01, 5'h02);
    step(1, 5'h01, 5'h02);
    check("post.rst.test_en", bus.test_en, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
